// File: rtl/sdcm_pkg.sv
// rtl/sdcm_pkg.sv - shared types and constants for the SD-card read responder
package sdcm_pkg;

    // Peripheral bus addresses of the data/command and status registers.
    localparam logic [7:0] SDCM_DADDR     = 8'h40;
    localparam logic [7:0] SDCM_SADDR     = 8'h41;

    // Command bytes written to the data/command register.
    localparam logic [7:0] SDCM_CMD_OPEN  = 8'h01;
    localparam logic [7:0] SDCM_CMD_FETCH = 8'h02;

    // Status register values.
    localparam logic [7:0] SDCM_ST_BUSY   = 8'h00;
    localparam logic [7:0] SDCM_ST_RDY    = 8'h01;
    localparam logic [7:0] SDCM_ST_ERR    = 8'h02;

    // Bytes per SD block.
    localparam int unsigned SDCM_BLK_LEN  = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_OPEN,
        ST_READY,
        ST_FETCH,
        ST_ERR
    } sdcm_state_t;

    function automatic logic [7:0] sdcm_status(input sdcm_state_t s);
        case (s)
            ST_IDLE, ST_READY: sdcm_status = SDCM_ST_RDY;
            ST_ERR:            sdcm_status = SDCM_ST_ERR;
            default:           sdcm_status = SDCM_ST_BUSY;
        endcase
    endfunction

endpackage

// File: rtl/sdcm_watchdog.sv
// rtl/sdcm_watchdog.sv - backend watchdog counter with clear, enable and terminal-count flag
//
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   clr    in   restart the count from zero
//   en     in   count while high; count is held at zero while low
//   tc     out  high while enabled and the count equals LIMIT-1
module sdcm_watchdog #(
    parameter logic [23:0] LIMIT = 24'd5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [23:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr || !en) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_q + 24'd1;
        end
    end

    assign tc = en && (cnt_q == LIMIT - 24'd1);

endmodule

// File: rtl/sdcm_regif.sv
// rtl/sdcm_regif.sv - CPU register responder driving the SD block-read handshake
//
// Optional feature: define SDCM_TIMEOUT_EN to add a watchdog that forces ERR
// (with a blk_abort pulse) when OPEN or FETCH lasts TIMEOUT_CYC cycles.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset (engine shares it)
//   bus_addr   in   peripheral address
//   bus_wdata  in   write data
//   bus_we     in   write strobe
//   bus_rdata  out  read data (status at SADDR, last byte at DADDR, else 0)
//   blk_addr   out  latched 32-bit block address, first written byte is LSB
//   blk_start  out  one-cycle pulse opening a block
//   blk_abort  out  one-cycle pulse dropping an open block
//   blk_rdy    in   engine: block opened
//   byte_req   out  one-cycle pulse requesting the next byte
//   byte_vld   in   engine: byte_data valid
//   byte_data  in   fetched byte
//   blk_err    in   engine error level
module sdcm_regif
    import sdcm_pkg::*;
#(
    parameter logic [7:0]  DADDR       = SDCM_DADDR,
    parameter logic [7:0]  SADDR       = SDCM_SADDR,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_we,
    output logic [7:0]  bus_rdata,
    output logic [31:0] blk_addr,
    output logic        blk_start,
    output logic        blk_abort,
    input  logic        blk_rdy,
    output logic        byte_req,
    input  logic        byte_vld,
    input  logic [7:0]  byte_data,
    input  logic        blk_err
);

    localparam logic [8:0] LAST_BYTE = 9'(SDCM_BLK_LEN - 1);

    sdcm_state_t state_q, state_d;
    logic [1:0]  addr_cnt;
    logic [8:0]  byte_cnt;
    logic [7:0]  data_q;

    logic data_wr;
    logic is_open, is_fetch;
    logic start_d, abort_d, req_d;
    logic addr_we, data_we;
    logic wd_tc;

    assign data_wr  = bus_we && (bus_addr == DADDR);
    assign is_open  = data_wr && (bus_wdata == SDCM_CMD_OPEN);
    assign is_fetch = data_wr && (bus_wdata == SDCM_CMD_FETCH);

`ifdef SDCM_TIMEOUT_EN
    logic wd_en, wd_clr;

    // Counts only while waiting on the engine; any state change restarts it.
    assign wd_en  = (state_q == ST_OPEN) || (state_q == ST_FETCH);
    assign wd_clr = (state_d != state_q);

    sdcm_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .en    (wd_en),
        .tc    (wd_tc)
    );
`else
    assign wd_tc = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        req_d   = 1'b0;
        addr_we = 1'b0;
        data_we = 1'b0;

        // Errors pre-empt every other event outside IDLE, including a
        // byte_vld in the same cycle, so that byte is never latched.
        if (state_q != ST_IDLE && (blk_err || wd_tc)) begin
            state_d = ST_ERR;
            abort_d = wd_tc;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_open) state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    // Every data write here is an address byte, command codes included.
                    if (data_wr) begin
                        addr_we = 1'b1;
                        if (addr_cnt == 2'd3) begin
                            state_d = ST_OPEN;
                            start_d = 1'b1;
                        end
                    end
                end
                ST_OPEN: begin
                    if (blk_rdy) state_d = ST_READY;
                end
                ST_READY: begin
                    if (is_open) begin
                        state_d = ST_ADDR;
                        abort_d = 1'b1;
                    end else if (is_fetch) begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (byte_vld) begin
                        data_we = 1'b1;
                        state_d = (byte_cnt == LAST_BYTE) ? ST_IDLE : ST_READY;
                    end
                end
                ST_ERR: begin
                    if (is_open) begin
                        state_d = ST_ADDR;
                        abort_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_cnt  <= 2'd0;
            byte_cnt  <= 9'd0;
            data_q    <= 8'h00;
            blk_addr  <= 32'h0;
            blk_start <= 1'b0;
            blk_abort <= 1'b0;
            byte_req  <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_start <= start_d;
            blk_abort <= abort_d;
            byte_req  <= req_d;

            if (state_d == ST_ADDR && state_q != ST_ADDR) begin
                addr_cnt <= 2'd0;
            end else if (addr_we) begin
                addr_cnt <= addr_cnt + 2'd1;
            end

            if (addr_we) begin
                blk_addr[8*addr_cnt +: 8] <= bus_wdata;
            end

            if (state_q == ST_OPEN && state_d == ST_READY) begin
                byte_cnt <= 9'd0;
            end else if (data_we) begin
                byte_cnt <= byte_cnt + 9'd1;
            end

            if (data_we) begin
                data_q <= byte_data;
            end
        end
    end

    always_comb begin
        bus_rdata = 8'h00;
        if (bus_addr == SADDR) begin
            bus_rdata = sdcm_status(state_q);
        end else if (bus_addr == DADDR) begin
            bus_rdata = data_q;
        end
    end

endmodule
